// File: rtl/waves_pkg.sv
// Shared definitions for the tt_um_waves_gen wave generator.
// Holds the waveform select encoding, noise LFSR seed and taps, and the
// quarter-wave sine ROM output width.
package waves_pkg;

   typedef enum logic [2:0] {
      WAVE_SQUARE  = 3'b000,
      WAVE_SAW     = 3'b001,
      WAVE_TRI     = 3'b010,
      WAVE_SINE    = 3'b011,
      WAVE_NOISE   = 3'b100,
      WAVE_PWM     = 3'b101,
      WAVE_INV_SAW = 3'b110,
      WAVE_DC      = 3'b111
   } wave_sel_e;

   // Noise LFSR reset value; an all-zero state would lock the LFSR.
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   // Feedback taps b15, b13, b12, b10 (x^16 + x^14 + x^13 + x^11 + 1).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned SINE_W = 7;

endpackage

// File: rtl/waves_sine_lut.sv
// Quarter-wave sine ROM: q = round(127 * sin((addr + 0.5) * pi / 128)).
// Ports:
//   addr  in   6        quarter-wave index 0..63
//   q     out  SINE_W   unsigned magnitude 2..127
module waves_sine_lut
   import waves_pkg::*;
(
   input  logic [5:0]        addr,
   output logic [SINE_W-1:0] q
);

   localparam logic [SINE_W-1:0] ROM [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
   };

   assign q = ROM[addr];

endmodule

// File: rtl/tt_um_waves_gen.sv
// Tiny Tapeout multifunction wave generator.
// A phase accumulator (step (F+1)<<4) selects a point on one of eight
// waveforms; the selected sample is registered onto uo_out for a DAC.
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  synchronous reset, active HIGH despite the name
//   ena      in   1  1 = run, 0 = hold all state
//   ui_in    in   8  [2:0] wave select, [7:3] frequency code F
//   uo_out   out  8  registered unsigned sample, 0x80 = midscale
//   uio_in   in   8  PWM duty D
//   uio_out  out  8  tied 0
//   uio_oe   out  8  tied 0 (uio pins are inputs)
module tt_um_waves_gen
   import waves_pkg::*;
#(
   parameter int unsigned ACC_W     = 16,
   parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  inc;
   logic [15:0]       lfsr;
   logic [7:0]        p;
   logic [7:0]        wave;
   logic [7:0]        sine;
   logic [5:0]        sine_addr;
   logic [SINE_W-1:0] sine_q;
   wave_sel_e         sel;

   assign uio_out = '0;
   assign uio_oe  = '0;

   assign sel = wave_sel_e'(ui_in[2:0]);
   // (F+1)<<4 written as F<<4 + 16
   assign inc = ACC_W'({ui_in[7:3], 4'b0000}) + ACC_W'(9'd16);
   assign p   = acc[ACC_W-1 -: 8];

   // Odd quadrants read the ROM backwards: 63 - x == ~x on 6 bits.
   assign sine_addr = p[6] ? ~p[5:0] : p[5:0];

   waves_sine_lut u_sine_lut (
      .addr (sine_addr),
      .q    (sine_q)
   );

   always_comb begin
      sine = p[7] ? (8'd127 - {1'b0, sine_q}) : (8'd128 + {1'b0, sine_q});
      wave = 8'h80;
      case (sel)
         WAVE_SQUARE:  wave = p[7] ? 8'hFF : 8'h00;
         WAVE_SAW:     wave = p;
         WAVE_TRI:     wave = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
         WAVE_SINE:    wave = sine;
         WAVE_NOISE:   wave = lfsr[7:0];
         WAVE_PWM:     wave = (p < uio_in) ? 8'hFF : 8'h00;
         WAVE_INV_SAW: wave = ~p;
         WAVE_DC:      wave = 8'h80;
         default:      wave = 8'h80;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         acc    <= '0;
         lfsr   <= LFSR_SEED;
         uo_out <= '0;
      end else if (ena) begin
         acc    <= acc + inc;
         lfsr   <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
         uo_out <= wave;
      end
   end

endmodule

// File: tb/tb_tt_um_waves_gen.sv
// Directed self-checking bench for tt_um_waves_gen.
module tb_tt_um_waves_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   tt_um_waves_gen dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two reset edges, then release; the next tick is run edge n=1 with acc=0.
   task automatic do_reset(input logic [7:0] ui);
      rst_n = 1'b1;
      ena   = 1'b1;
      ui_in = ui;
      tick();
      tick();
      rst_n = 1'b0;
   endtask

   initial begin
      logic [15:0] m;
      logic [7:0]  vmax;
      logic [7:0]  vmin;

      rst_n  = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'hFB;
      uio_in = 8'h00;

      // Reset state
      do_reset(8'hFB);
      check("rst uo_out", uo_out, 8'h00);
      check("rst acc", dut.acc, 16'h0000);
      check("rst lfsr", dut.lfsr, 16'hACE1);
      check("rst uio_out", uio_out, 8'h00);
      check("rst uio_oe", uio_oe, 8'h00);

      // Saw, F=0: uo after edge n is ((n-1)*16)>>8, wrapping at n=4097
      do_reset(8'h01);
      for (int n = 1; n <= 4098; n++) begin
         tick();
         check("saw", uo_out, 32'(((n - 1) * 16 / 256) % 256));
      end

      // Square, F=31: 64 clocks low, 64 clocks high
      do_reset(8'hF8);
      for (int n = 1; n <= 256; n++) begin
         tick();
         check("square", uo_out, (((n - 1) % 128) < 64) ? 32'h00 : 32'hFF);
      end

      // Triangle, F=31: p = 2(n-1)
      do_reset(8'hFA);
      for (int n = 1; n <= 128; n++) begin
         tick();
         case (n)
            1:   check("tri p00", uo_out, 8'h00);
            2:   check("tri p02", uo_out, 8'h04);
            64:  check("tri p7E", uo_out, 8'hFC);
            65:  check("tri p80", uo_out, 8'hFF);
            66:  check("tri p82", uo_out, 8'hFB);
            128: check("tri pFE", uo_out, 8'h03);
            default: ;
         endcase
      end

      // Sine, F=31: hand-computed points, plus extremes over one period
      do_reset(8'hFB);
      vmax = 8'h00;
      vmin = 8'hFF;
      for (int n = 1; n <= 128; n++) begin
         tick();
         if (uo_out > vmax) vmax = uo_out;
         if (uo_out < vmin) vmin = uo_out;
         case (n)
            1:   check("sine p00", uo_out, 8'h82);
            2:   check("sine p02", uo_out, 8'h88);
            17:  check("sine p20", uo_out, 8'hDB);
            32:  check("sine p3E", uo_out, 8'hFF);
            33:  check("sine p40", uo_out, 8'hFF);
            49:  check("sine p60", uo_out, 8'hD9);
            65:  check("sine p80", uo_out, 8'h7D);
            81:  check("sine pA0", uo_out, 8'h24);
            97:  check("sine pC0", uo_out, 8'h00);
            128: check("sine pFE", uo_out, 8'h7A);
            default: ;
         endcase
      end
      check("sine max", vmax, 8'hFF);
      check("sine min", vmin, 8'h00);

      // Noise: first samples by hand, then against an LFSR model
      do_reset(8'h04);
      m = 16'hACE1;
      for (int n = 1; n <= 300; n++) begin
         tick();
         case (n)
            1: check("noise n1", uo_out, 8'hE1);
            2: check("noise n2", uo_out, 8'hC3);
            3: check("noise n3", uo_out, 8'h87);
            4: check("noise n4", uo_out, 8'h0F);
            default: ;
         endcase
         check("noise seq", uo_out, m[7:0]);
         check("lfsr nonzero", 32'(dut.lfsr != 16'h0000), 32'd1);
         m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      end

      // Inverted saw and midscale, F=0
      do_reset(8'h06);
      for (int n = 1; n <= 33; n++) begin
         tick();
         case (n)
            1:  check("isaw n1", uo_out, 8'hFF);
            17: check("isaw n17", uo_out, 8'hFE);
            33: check("isaw n33", uo_out, 8'hFD);
            default: ;
         endcase
      end
      do_reset(8'h07);
      tick();
      check("dc n1", uo_out, 8'h80);
      tick();
      check("dc n2", uo_out, 8'h80);

      // PWM, D=0x40, F=0: high while p<64, i.e. edges 1..1024
      uio_in = 8'h40;
      do_reset(8'h05);
      for (int n = 1; n <= 1030; n++) begin
         tick();
         case (n)
            1:    check("pwm n1", uo_out, 8'hFF);
            1024: check("pwm n1024", uo_out, 8'hFF);
            1025: check("pwm n1025", uo_out, 8'h00);
            1030: check("pwm n1030", uo_out, 8'h00);
            default: ;
         endcase
      end

      // Freeze: acc=1030*16 held; a duty change must not reach uo_out
      ena    = 1'b0;
      uio_in = 8'h50;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("freeze uo", uo_out, 8'h00);
         check("freeze acc", dut.acc, 16'd16480);
      end
      ena = 1'b1;
      tick();
      check("resume uo", uo_out, 8'hFF);
      check("resume acc", dut.acc, 16'd16496);
      uio_in = 8'h00;
      tick();
      check("pwm d00", uo_out, 8'h00);
      uio_in = 8'hFF;
      tick();
      check("pwm dFF", uo_out, 8'hFF);

      // Reset mid-run takes priority over ena=0
      rst_n = 1'b1;
      ena   = 1'b0;
      tick();
      check("midrst uo", uo_out, 8'h00);
      check("midrst acc", dut.acc, 16'h0000);
      check("midrst lfsr", dut.lfsr, 16'hACE1);
      rst_n = 1'b0;
      ena   = 1'b1;

      check("end uio_out", uio_out, 8'h00);
      check("end uio_oe", uio_oe, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
